// File: rtl/elixirchip_es1_spu_op_mem_pkg.sv
// Shared definitions for the ES1 SPU memory operators: read-during-write policy names,
// lane helpers and parameter legality checks.
package elixirchip_es1_spu_op_mem_pkg;

  localparam string RDW_READ_FIRST  = "read_first";
  localparam string RDW_WRITE_FIRST = "write_first";

  // Helpers work on a padded word so one function serves every DATA_BITS setting.
  localparam int MAX_DATA_BITS = 256;
  typedef logic [MAX_DATA_BITS-1:0] word_t;

  function automatic int lane_width(input int data_bits, input int we_bits);
    return data_bits / we_bits;
  endfunction

  // strb holds one bit per lane starting at bit 0.
  function automatic word_t lane_merge(input word_t old_word, input word_t new_word,
                                       input word_t strb, input int lane_bits);
    word_t merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (strb[i / lane_bits]) begin
        merged[i] = new_word[i];
      end
    end
    return merged;
  endfunction

  function automatic bit latency_ok(input int latency);
    return (latency >= 1) && (latency <= 4);
  endfunction

  function automatic bit lanes_ok(input int data_bits, input int we_bits);
    return (we_bits > 0) && (data_bits <= MAX_DATA_BITS) && ((data_bits % we_bits) == 0);
  endfunction

  function automatic bit size_ok(input int mem_size, input int addr_bits);
    return (mem_size >= 1) && (mem_size <= (1 << addr_bits));
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mem_sdp_chk.sv
// Simulation-only parameter and input sanity checks for the simple-dual-port memory op.
module elixirchip_es1_spu_op_mem_sdp_chk
  import elixirchip_es1_spu_op_mem_pkg::*;
#(
  parameter int    LATENCY   = 2,
  parameter int    DATA_BITS = 18,
  parameter int    WE_BITS   = 1,
  parameter int    ADDR_BITS = 10,
  parameter int    MEM_SIZE  = 2 ** ADDR_BITS,
  parameter string RDW_MODE  = "read_first",
  parameter string MEM_TYPE  = "block",
  parameter string DEVICE    = "RTL",
  parameter string DEBUG     = "false"
) (
  input logic clk,
  input logic reset,
  input logic cke,
  input logic s_wvalid,
  input logic s_rvalid
);

  // configuration legality plus X detection on the request strobes
  always @(posedge clk) begin
    if (!reset) begin
      assert (latency_ok(LATENCY)) else $error("LATENCY %0d outside 1..4", LATENCY);
      assert (lanes_ok(DATA_BITS, WE_BITS))
        else $error("DATA_BITS %0d not divisible by WE_BITS %0d", DATA_BITS, WE_BITS);
      assert (size_ok(MEM_SIZE, ADDR_BITS))
        else $error("MEM_SIZE %0d exceeds 2**%0d", MEM_SIZE, ADDR_BITS);
      assert ((RDW_MODE == RDW_READ_FIRST) || (RDW_MODE == RDW_WRITE_FIRST))
        else $error("RDW_MODE %s unknown", RDW_MODE);
      assert ((MEM_TYPE == "block") || (MEM_TYPE == "distributed"))
        else $error("MEM_TYPE %s unknown", MEM_TYPE);
      assert ((DEBUG == "true") || (DEBUG == "false")) else $error("DEBUG %s unknown", DEBUG);
      assert (DEVICE != "") else $error("DEVICE is empty");
      if (cke) begin
        assert (!$isunknown(s_rvalid)) else $error("s_rvalid is X while enabled");
        assert (!$isunknown(s_wvalid)) else $error("s_wvalid is X while enabled");
      end
    end
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_sdp_pipe.sv
// cke-gated valid+data delay line; each data stage loads only when a valid word arrives.
module elixirchip_es1_spu_op_mem_sdp_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_stages
    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];

    // shift valid every enabled edge, move data only behind a valid bit
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_r <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_r[i] <= '0;
        end
      end else if (cke) begin
        valid_r[0] <= in_valid;
        if (in_valid) begin
          data_r[0] <= in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
          valid_r[i] <= valid_r[i-1];
          if (valid_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end
        end
      end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_sdp.sv
// Simple-dual-port memory operator: strobed write port, pipelined read port with
// selectable read-during-write result and zero data for out-of-range reads.
module elixirchip_es1_spu_op_mem_sdp
  import elixirchip_es1_spu_op_mem_pkg::*;
#(
  parameter int    LATENCY    = 2,
  parameter int    DATA_BITS  = 18,
  parameter int    WE_BITS    = 1,
  parameter int    ADDR_BITS  = 10,
  parameter int    MEM_SIZE   = 2 ** ADDR_BITS,
  parameter string RDW_MODE   = "read_first",
  parameter string MEM_TYPE   = "block",
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 cke,
  input  logic [ADDR_BITS-1:0] s_waddr,
  input  logic [DATA_BITS-1:0] s_wdata,
  input  logic [WE_BITS-1:0]   s_wstrb,
  input  logic                 s_wvalid,
  input  logic [ADDR_BITS-1:0] s_raddr,
  input  logic                 s_rvalid,
  output logic [DATA_BITS-1:0] m_rdata,
  output logic                 m_rvalid
);

  localparam int               LANE_BITS   = lane_width(DATA_BITS, WE_BITS);
  localparam logic [ADDR_BITS:0] MEM_LIMIT = (ADDR_BITS + 1)'(MEM_SIZE);
  localparam bit               WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  (* ram_style = MEM_TYPE *)
  logic [DATA_BITS-1:0] mem [MEM_SIZE];

  logic                 wr_en;
  logic                 rd_in_range;
  logic                 hit;
  logic                 s1_valid;
  logic                 s1_oor;
  logic                 s1_hit;
  logic [DATA_BITS-1:0] s1_ram;
  logic [DATA_BITS-1:0] s1_wdata;
  logic [WE_BITS-1:0]   s1_wstrb;
  logic [DATA_BITS-1:0] s1_data;

  assign wr_en       = cke & s_wvalid & ({1'b0, s_waddr} < MEM_LIMIT);
  assign rd_in_range = ({1'b0, s_raddr} < MEM_LIMIT);
  // wr_en already implies the shared address is in range
  assign hit         = WRITE_FIRST & wr_en & (s_waddr == s_raddr);

  // strobed write port; array contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WE_BITS; i++) begin
        if (s_wstrb[i]) begin
          mem[s_waddr][i*LANE_BITS +: LANE_BITS] <= s_wdata[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  // stage 1: array read register plus range flag and write-first bypass capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s1_hit   <= 1'b0;
      s1_ram   <= '0;
      s1_wdata <= '0;
      s1_wstrb <= '0;
    end else if (cke) begin
      s1_valid <= s_rvalid;
      if (s_rvalid) begin
        s1_oor   <= ~rd_in_range;
        s1_hit   <= hit;
        s1_wdata <= s_wdata;
        s1_wstrb <= s_wstrb;
        if (rd_in_range) begin
          s1_ram <= mem[s_raddr];
        end
      end
    end
  end

  // per-lane bypass mux: the array register holds the pre-write word on a collision
  always_comb begin
    s1_data = s1_ram;
    if (s1_oor) begin
      s1_data = '0;
    end else if (s1_hit) begin
      s1_data = DATA_BITS'(lane_merge(word_t'(s1_ram), word_t'(s1_wdata),
                                      word_t'(s1_wstrb), LANE_BITS));
    end else begin
      s1_data = s1_ram;
    end
  end

  elixirchip_es1_spu_op_mem_sdp_pipe #(
    .DEPTH (LATENCY - 1),
    .WIDTH (DATA_BITS)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .out_valid (m_rvalid),
    .out_data  (m_rdata)
  );

  if (SIMULATION == "true") begin : g_chk
    elixirchip_es1_spu_op_mem_sdp_chk #(
      .LATENCY   (LATENCY),
      .DATA_BITS (DATA_BITS),
      .WE_BITS   (WE_BITS),
      .ADDR_BITS (ADDR_BITS),
      .MEM_SIZE  (MEM_SIZE),
      .RDW_MODE  (RDW_MODE),
      .MEM_TYPE  (MEM_TYPE),
      .DEVICE    (DEVICE),
      .DEBUG     (DEBUG)
    ) u_chk (
      .clk      (clk),
      .reset    (reset),
      .cke      (cke),
      .s_wvalid (s_wvalid),
      .s_rvalid (s_rvalid)
    );
  end

endmodule

// File: doc/elixirchip_es1_spu_op_mem_sdp.md
Name: elixirchip_es1_spu_op_mem_sdp

Overview:
Simple-dual-port memory operator for the ES1 SPU op library; the parametrised successor of the single-port mem op.
- Provides an independent write port and read port in one clock domain.
- Adds per-lane write strobes, a selectable read-during-write policy, a valid-tracked read pipeline of configurable latency, and out-of-range address handling.
- Instantiated by SPU datapaths as scratch/line buffer storage; synthesises to block or distributed RAM.

Parameters:
- LATENCY, 2, read latency in cke-qualified cycles from s_rvalid to m_rvalid; legal range 1..4.
- DATA_BITS, 18, word width.
- WE_BITS, 1, number of write lanes; DATA_BITS must divide evenly; lane width = DATA_BITS/WE_BITS.
- ADDR_BITS, 10, address width.
- MEM_SIZE, 2**ADDR_BITS, number of words; must be <= 2**ADDR_BITS.
- RDW_MODE, "read_first", same-address read/write result policy: "read_first" or "write_first".
- MEM_TYPE, "block", "block" or "distributed".
- DEVICE, "RTL", target device name.
- SIMULATION, "false", enables simulation-only checks.
- DEBUG, "false", enables debug attributes.

Ports:
- reset, input, 1, asynchronous active-high reset.
- clk, input, 1, clock; all logic is on the rising edge.
- cke, input, 1, clock enable; low freezes all state.
- s_waddr, input, ADDR_BITS, write address.
- s_wdata, input, DATA_BITS, write data.
- s_wstrb, input, WE_BITS, lane write enables.
- s_wvalid, input, 1, write request.
- s_raddr, input, ADDR_BITS, read address.
- s_rvalid, input, 1, read request.
- m_rdata, output, DATA_BITS, read data.
- m_rvalid, output, 1, read data valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting reset immediately clears m_rvalid, m_rdata and all internal valid/data pipeline stages to 0.
  - Array contents are not reset and survive reset.
  - In-flight reads are dropped: no m_rvalid pulse after reset deasserts.
- Write: on a clk edge with cke=1, s_wvalid=1 and s_waddr<MEM_SIZE, lane i is written only where s_wstrb[i]=1. Unstrobed lanes keep their old value. A write with s_wstrb=0 is a no-op.
- Read: a read is accepted on an edge with cke=1 and s_rvalid=1.
  - m_rvalid pulses exactly LATENCY cke-qualified edges later.
  - m_rdata carries the result in that same cycle.
  - Back-to-back reads give back-to-back results; throughput is 1 per cycle with no stalls.
- Pipeline structure:
  - Stage 1 is the array read register.
  - Stages 2..LATENCY are output registers.
  - Valid and address-range flags travel alongside the data.
- m_rdata updates only when a valid result arrives and holds its value otherwise.
- cke=0: no writes, no reads accepted, pipeline frozen; outputs hold.
- Out-of-range: s_waddr>=MEM_SIZE writes are ignored. s_raddr>=MEM_SIZE reads return all-zero data with m_rvalid still asserted.
- Same-address collision (read and write on the same edge, same in-range address):
  - read_first: returns the pre-write word.
  - write_first: returns the merged word, i.e. strobed lanes from s_wdata and other lanes from the old word. Implemented with a bypass register and per-lane mux at stage 1, independent of RAM primitive mode.
- Different addresses on the same edge: fully independent.
- SIMULATION="true": assertions fire on the following:
  - LATENCY outside 1..4.
  - DATA_BITS % WE_BITS != 0.
  - MEM_SIZE > 2**ADDR_BITS.
  - X on s_rvalid or s_wvalid while cke=1 and reset is not asserted.

Decomposition:
- Package elixirchip_es1_spu_op_mem_pkg: RDW_MODE string constants, a lane-width function, a lane-merge function (old, new, strb), and parameter-legality check functions, shared with the single-port op.
- Sub-module elixirchip_es1_spu_op_mem_sdp_pipe: cke-gated valid+data delay line of depth LATENCY-1, with async reset of the valid bits and data, and hold-on-invalid data behaviour.

Test Plan:
1. LATENCY=2, WE_BITS=1: write 0x155AA at 5, then read 5 one cycle later -> m_rvalid=1 exactly 2 edges after the read, m_rdata=0x155AA.
2. WE_BITS=2 (9-bit lanes): write 0x3FFFF at 7, then write 0x00000 with strb=2'b01 -> reading 7 returns 0x3FE00.
3. Collision at address 3, old 0x00011, new 0x00022, strb all-ones: read_first -> 0x00011; write_first -> 0x00022. With WE_BITS=2, strb=2'b10 and new 0x3FE00: write_first -> 0x3FE11.
4. Stream reads of addresses 0..7 while toggling cke every other cycle -> 8 m_rvalid pulses, in order, each LATENCY cke-high edges after its read; outputs held while cke=0.
5. MEM_SIZE=1000, ADDR_BITS=10: write 0x12345 to 1000, then read 1000 -> m_rvalid=1, m_rdata=0; address 999 is unchanged.
6. LATENCY=4: issue 3 reads, assert reset one cycle later -> m_rvalid/m_rdata go to 0 immediately, no pulses after release; a re-read of a pre-reset written address returns the old contents.
